// File: rtl/wide_arith_pkg.sv
// Shared definitions for the multi-limb carry-select adder/subtractor.
//   DEF_LIMB_W  : default width of one limb adder
//   DEF_N_LIMBS : default number of limbs
//   state_t     : sequencer states IDLE -> CALC0 -> CALC1 -> RESOLVE -> HOLD
package wide_arith_pkg;

    localparam int unsigned DEF_LIMB_W  = 256;
    localparam int unsigned DEF_N_LIMBS = 13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC0   = 3'd1,
        CALC1   = 3'd2,
        RESOLVE = 3'd3,
        HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/wide_addsub_cs_if.sv
// Operand/result handshake bundle for wide_addsub_cs.
//   in_valid/in_ready   : operand handshake (op_sub, a, b)
//   out_valid/out_ready : result handshake (sum, carry_out)
//   master : producer/consumer side, slave : the arithmetic block
interface wide_addsub_cs_if
    import wide_arith_pkg::*;
#(
    parameter int unsigned W = DEF_LIMB_W * DEF_N_LIMBS
);
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
endinterface

// File: rtl/wide_addsub_limb.sv
// Combinational single-limb adder: {cout, s} = a + b + cin.
//   a, b : LIMB_W-bit addends
//   cin  : carry in
//   s    : LIMB_W-bit sum, cout : carry out
module wide_addsub_limb
    import wide_arith_pkg::*;
#(
    parameter int unsigned LIMB_W = DEF_LIMB_W
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] s,
    output logic              cout
);
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    end
endmodule

// File: rtl/wide_addsub_cs.sv
// Multi-limb carry-select adder/subtractor, W = LIMB_W*N_LIMBS.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of wide_addsub_cs_if
//              (in_valid/in_ready/op_sub/a/b in, out_valid/out_ready/sum/carry_out out)
// Each limb is summed with carry-in 0 (CALC0) then 1 (CALC1) on the same
// adders; RESOLVE walks the carry chain selecting the matching partial sum.
module wide_addsub_cs
    import wide_arith_pkg::*;
#(
    parameter int unsigned LIMB_W  = DEF_LIMB_W,
    parameter int unsigned N_LIMBS = DEF_N_LIMBS
) (
    input  logic             clk,
    input  logic             rst,
    wide_addsub_cs_if.slave  bus
);
    localparam int unsigned W = LIMB_W * N_LIMBS;

    state_t                      state;
    logic [W-1:0]                a_q;
    logic [W-1:0]                b_q;
    logic                        op_sub_q;
    logic [N_LIMBS-1:0][LIMB_W:0] s0;
    logic [N_LIMBS-1:0][LIMB_W:0] s1;
    logic [N_LIMBS-1:0][LIMB_W:0] limb_res;
    logic                        limb_cin;
    logic [W-1:0]                sum_q;
    logic                        carry_q;
    logic                        out_valid_q;
    logic [W-1:0]                sum_nxt;
    logic [N_LIMBS:0]            c;
    logic [LIMB_W:0]             sel;

    // The same adders serve both passes; only the carry-in differs.
    assign limb_cin = (state == CALC1);

    for (genvar i = 0; i < int'(N_LIMBS); i++) begin : g_limb
        wide_addsub_limb #(
            .LIMB_W(LIMB_W)
        ) u_limb (
            .a    (a_q[i*LIMB_W +: LIMB_W]),
            .b    (b_q[i*LIMB_W +: LIMB_W]),
            .cin  (limb_cin),
            .s    (limb_res[i][LIMB_W-1:0]),
            .cout (limb_res[i][LIMB_W])
        );
    end

    // Carry-select chain; for SUB the +1 of two's complement enters as c[0].
    always_comb begin
        c       = '0;
        sum_nxt = '0;
        sel     = '0;
        c[0]    = op_sub_q;
        for (int unsigned i = 0; i < N_LIMBS; i++) begin
            sel                          = c[i] ? s1[i] : s0[i];
            sum_nxt[i*LIMB_W +: LIMB_W]  = sel[LIMB_W-1:0];
            c[i+1]                       = sel[LIMB_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_sub_q    <= 1'b0;
            s0          <= '0;
            s1          <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.op_sub ? ~bus.b : bus.b;
                        op_sub_q <= bus.op_sub;
                        state    <= CALC0;
                    end
                end
                CALC0: begin
                    s0    <= limb_res;
                    state <= CALC1;
                end
                CALC1: begin
                    s1    <= limb_res;
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    sum_q       <= sum_nxt;
                    carry_q     <= op_sub_q ? ~c[N_LIMBS] : c[N_LIMBS];
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
endmodule
